// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// rtl/ysyx_25030093_mem_arbiter_if.sv - request/response bus bundle for the memory arbiter
//
// Purpose: one request channel (valid/ready/addr/wen/wdata/wmask) and one
//          response channel (valid/rdata/err). The same bundle is used for
//          the IFU, LSU and memory sides of the arbiter.
// Modports:
//   master  drives the request fields and receives ready and the response
//   slave   receives the request fields and drives ready and the response
interface ysyx_25030093_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_wen;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wmask;
  logic            resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// rtl/ysyx_25030093_mem_arbiter.sv - IFU/LSU arbiter for the single physical-memory port
//
// Purpose: grants one of IFU / LSU, registers the winning request, holds it
//          on the memory port until accepted, waits for the response under a
//          watchdog and returns it to the owner as a one-cycle pulse.
//          One transaction is in flight at a time.
// Arbitration: LSU wins over IFU on simultaneous requests by default.
//          Define ARB_RR_EN for round-robin: the port that did not win the
//          previous grant wins a tie.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous reset, active low
//   i_ifu   IFU port (slave); only req_valid/req_addr are used
//   i_lsu   LSU port (slave)
//   o_mem   memory port (master); resp_err from memory is ignored
module ysyx_25030093_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic                         i_clk,
  input logic                         i_rst,
  ysyx_25030093_mem_arbiter_if.slave  i_ifu,
  ysyx_25030093_mem_arbiter_if.slave  i_lsu,
  ysyx_25030093_mem_arbiter_if.master o_mem
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last WAIT cycle index: the watchdog fires after TIMEOUT WAIT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_owner;   // 0 = IFU, 1 = LSU
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wmask;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic [7:0]      r_timer;

  logic w_pick_ls;
  logic w_grant;
  logic w_capture;
  logic w_timeout;
  logic w_clr_timer;
  logic w_inc_timer;
  logic w_if_resp;
  logic w_ls_resp;
  logic w_unused;

`ifdef ARB_RR_EN
  // r_owner only changes on a grant, so it already holds the last winner.
  assign w_pick_ls = i_lsu.req_valid && (!i_ifu.req_valid || !r_owner);
`else
  assign w_pick_ls = i_lsu.req_valid;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_clr_timer = 1'b0;
    w_inc_timer = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ifu.req_valid || i_lsu.req_valid) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (o_mem.req_ready) begin
          w_clr_timer = 1'b1;
          // A response arriving with the handshake skips WAIT entirely.
          if (o_mem.resp_valid) begin
            w_capture = 1'b1;
            w_next    = S_RESP;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A response in the final watchdog cycle still wins over the timeout.
        if (o_mem.resp_valid) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (r_timer == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_inc_timer = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_pick_ls;
        if (w_pick_ls) begin
          r_addr  <= i_lsu.req_addr;
          r_wen   <= i_lsu.req_wen;
          r_wdata <= i_lsu.req_wdata;
          r_wmask <= i_lsu.req_wmask;
        end else begin
          r_addr  <= i_ifu.req_addr;
          r_wen   <= 1'b0;
          r_wdata <= '0;
          r_wmask <= '0;
        end
      end
      if (w_clr_timer)      r_timer <= '0;
      else if (w_inc_timer) r_timer <= r_timer + 8'd1;
      if (w_capture) begin
        r_rdata <= r_wen ? '0 : o_mem.resp_rdata;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign i_ifu.req_ready = w_grant && !w_pick_ls;
  assign i_lsu.req_ready = w_grant && w_pick_ls;

  assign o_mem.req_valid = (r_state == S_ISSUE);
  assign o_mem.req_addr  = r_addr;
  assign o_mem.req_wen   = r_wen;
  assign o_mem.req_wdata = r_wdata;
  assign o_mem.req_wmask = r_wmask;

  assign w_if_resp        = (r_state == S_RESP) && !r_owner;
  assign w_ls_resp        = (r_state == S_RESP) && r_owner;
  assign i_ifu.resp_valid = w_if_resp;
  assign i_ifu.resp_rdata = w_if_resp ? r_rdata : '0;
  assign i_ifu.resp_err   = w_if_resp && r_err;
  assign i_lsu.resp_valid = w_ls_resp;
  assign i_lsu.resp_rdata = w_ls_resp ? r_rdata : '0;
  assign i_lsu.resp_err   = w_ls_resp && r_err;

  // IFU is read-only and memory never signals errors itself.
  assign w_unused = ^{i_ifu.req_wen, i_ifu.req_wdata, i_ifu.req_wmask, o_mem.resp_err};
endmodule
